// File: rtl/hack_pkg.sv
// Shared types and constants for the fetch stage.
//   ADDR_W / DATA_W : ROM address (PC) width and instruction width
//   addr_t / word_t : PC and instruction word types
//   fetch_state_t   : fetch FSM states
package hack_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM port, redirect/halt control, decode handshake.
//   master : the fetch stage (drives rom_adr, ins_*, halted)
//   slave  : ROM + control + decode side
interface instruction_fetch_if;
    import hack_pkg::*;

    addr_t rom_adr;
    word_t rom_data;
    logic  jump_en;
    addr_t jump_adr;
    logic  halt;
    logic  ins_valid;
    logic  ins_ready;
    word_t ins_out;
    addr_t ins_pc;
    logic  halted;

    modport master (
        output rom_adr, ins_valid, ins_out, ins_pc, halted,
        input  rom_data, jump_en, jump_adr, halt, ins_ready
    );

    modport slave (
        input  rom_adr, ins_valid, ins_out, ins_pc, halted,
        output rom_data, jump_en, jump_adr, halt, ins_ready
    );
endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register.
//   clk, rst_n  : clock, async active-low reset (to RESET_PC)
//   load_i      : load load_val_i (highest priority)
//   load_val_i  : redirect target
//   inc_i       : advance by one, wrapping modulo 2^ADDR_W
//   pc_o        : current PC
module pc_reg
    import hack_pkg::*;
#(
    parameter addr_t RESET_PC = '0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  addr_t load_val_i,
    input  logic  inc_i,
    output addr_t pc_o
);
    addr_t pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = load_val_i;
        else if (inc_i)
            pc_d = pc_q + addr_t'(1);  // natural wrap, no carry out
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage in front of the instruction ROM.
//   clk, rst_n : clock, async active-low reset
//   bus        : ROM address/data, jump/halt control, decode valid/ready
//                handshake with registered ins_out/ins_pc, halted status
// Holds one instruction in an output register; a jump flushes it.
module instruction_fetch
    import hack_pkg::*;
#(
    parameter addr_t RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus
);
    fetch_state_t state_q, state_d;
    logic         ins_valid_q;
    word_t        ins_out_q;
    addr_t        ins_pc_q;
    logic         halted_q;
    addr_t        pc;
    logic         slot_free;
    logic         fetch;

    assign slot_free = !ins_valid_q || bus.ins_ready;

    // A fetch needs RUN state *and* halt low now: the edge that sees halt
    // rise is already fetch-free, and the edge leaving HALTED is too.
    assign fetch = !bus.jump_en && (state_q == RUN) && !bus.halt && slot_free;

    // halt decides the next state even when a jump takes priority.
    assign state_d = bus.halt ? HALTED : RUN;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (bus.jump_en),
        .load_val_i (bus.jump_adr),
        .inc_i      (fetch),
        .pc_o       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            halted_q    <= 1'b0;
            ins_valid_q <= 1'b0;
            ins_out_q   <= '0;
            ins_pc_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALTED);
            if (bus.jump_en) begin
                // flush: buffered instruction is dropped even if decode
                // was accepting it this cycle
                ins_valid_q <= 1'b0;
            end else if (fetch) begin
                ins_out_q   <= bus.rom_data;
                ins_pc_q    <= pc;
                ins_valid_q <= 1'b1;
            end else if (ins_valid_q && bus.ins_ready) begin
                ins_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rom_adr   = pc;
    assign bus.ins_valid = ins_valid_q;
    assign bus.ins_out   = ins_out_q;
    assign bus.ins_pc    = ins_pc_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import hack_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  jump_en = 1'b0;
    addr_t jump_adr = '0;
    logic  halt = 1'b0;
    logic  ins_ready = 1'b1;
    int    checks = 0;
    int    failures = 0;

    // behavioural model state
    int    m_pc;
    bit    m_valid;
    int    m_out;
    int    m_ipc;
    bit    m_halted;

    instruction_fetch_if bus();

    always #5 clk = ~clk;

    function automatic word_t rom_f(addr_t a);
        logic [15:0] s;
        s = 16'hA000 + {1'b0, a};
        return s;
    endfunction

    assign bus.rom_data  = rom_f(bus.rom_adr);
    assign bus.jump_en   = jump_en;
    assign bus.jump_adr  = jump_adr;
    assign bus.halt      = halt;
    assign bus.ins_ready = ins_ready;

    instruction_fetch #(.RESET_PC('0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: one edge applies the first matching rule in priority order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_valid = 0; m_out = 0; m_ipc = 0; m_halted = 0;
        end else begin
            if (jump_en) begin
                m_pc = int'(jump_adr);
                m_valid = 0;
            end else if (!m_halted && !halt && (!m_valid || ins_ready)) begin
                m_out = int'(rom_f(addr_t'(m_pc)));
                m_ipc = m_pc;
                m_valid = 1;
                m_pc = (m_pc + 1) % 32768;
            end else if (m_valid && ins_ready) begin
                m_valid = 0;
            end
            m_halted = halt;
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", 32'(bus.ins_valid), 32'(m_valid));
            chk("m_halted", 32'(bus.halted), 32'(m_halted));
            chk("m_rom_adr", 32'(bus.rom_adr), 32'(m_pc));
            if (m_valid) begin
                chk("m_ins_pc", 32'(bus.ins_pc), 32'(m_ipc));
                chk("m_ins_out", 32'(bus.ins_out), 32'(m_out));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ins(input string nm, input logic v, input int pc, input int out);
        chk({nm, "_valid"}, 32'(bus.ins_valid), 32'(v));
        if (v) begin
            chk({nm, "_pc"}, 32'(bus.ins_pc), 32'(pc));
            chk({nm, "_out"}, 32'(bus.ins_out), 32'(out));
        end
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_valid", 32'(bus.ins_valid), 32'd0);
        chk("rst_out", 32'(bus.ins_out), 32'd0);
        chk("rst_pc", 32'(bus.ins_pc), 32'd0);
        chk("rst_rom_adr", 32'(bus.rom_adr), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        step(); step();
        rst_n = 1'b1;

        // 1: streaming from RESET_PC
        for (int i = 0; i < 3; i++) begin
            step();
            expect_ins("stream", 1'b1, i, 32'hA000 + i);
        end

        // 2: stall on ins_pc=2
        ins_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_ins("stall", 1'b1, 2, 32'hA002);
            chk("stall_rom_adr", 32'(bus.rom_adr), 32'd3);
        end
        ins_ready = 1'b1;
        step();
        expect_ins("unstall", 1'b1, 3, 32'hA003);

        // 3: jump while stalled
        ins_ready = 1'b0;
        step();
        expect_ins("prejump", 1'b1, 3, 32'hA003);
        jump_en = 1'b1; jump_adr = 15'h0100;
        step();
        jump_en = 1'b0; ins_ready = 1'b1;
        expect_ins("flush", 1'b0, 0, 0);
        chk("flush_rom_adr", 32'(bus.rom_adr), 32'h100);
        step();
        expect_ins("jump", 1'b1, 32'h100, 32'hA100);

        // 4: PC wrap
        jump_en = 1'b1; jump_adr = 15'h7FFE;
        step();
        jump_en = 1'b0;
        step(); expect_ins("wrap0", 1'b1, 32'h7FFE, 32'h1FFE);
        step(); expect_ins("wrap1", 1'b1, 32'h7FFF, 32'h1FFF);
        step(); expect_ins("wrap2", 1'b1, 32'h0000, 32'hA000);
        step(); expect_ins("wrap3", 1'b1, 32'h0001, 32'hA001);

        // 5: halt for 4 cycles
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_halted", 32'(bus.halted), 32'd1);
            chk("halt_valid", 32'(bus.ins_valid), 32'd0);
            chk("halt_rom_adr", 32'(bus.rom_adr), 32'd2);
        end
        halt = 1'b0;
        step();
        chk("unhalt_halted", 32'(bus.halted), 32'd0);
        chk("unhalt_valid", 32'(bus.ins_valid), 32'd0);
        step();
        expect_ins("resume", 1'b1, 2, 32'hA002);

        // 6: reset mid-stream with a jump pending
        ins_ready = 1'b0;
        jump_en = 1'b1; jump_adr = 15'h0555;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.ins_valid), 32'd0);
        chk("arst_out", 32'(bus.ins_out), 32'd0);
        chk("arst_pc", 32'(bus.ins_pc), 32'd0);
        chk("arst_rom_adr", 32'(bus.rom_adr), 32'd0);
        chk("arst_halted", 32'(bus.halted), 32'd0);
        jump_en = 1'b0;
        step(); step();
        rst_n = 1'b1; ins_ready = 1'b1;
        step(); expect_ins("restart0", 1'b1, 0, 32'hA000);
        step(); expect_ins("restart1", 1'b1, 1, 32'hA001);

        // random phase, checked by the compare process against the model
        for (int i = 0; i < 3000; i++) begin
            ins_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0) halt = ~halt;
            jump_en = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                jump_adr = addr_t'(15'h7FFC + $urandom_range(0, 3));
            else
                jump_adr = addr_t'($urandom_range(0, 32767));
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
